// File: rtl/cipher_dma.sv
// rtl/cipher_dma.sv - memory-to-memory LFSR stream-cipher DMA engine
//
// Reads LEN words from SRC, XORs each with a 32-bit LFSR keystream seeded
// from KEY and writes the result to DST. Encryption and decryption are the
// same operation.
//
// Ports:
//   clk_i, rst_ni   clock (rising edge), asynchronous active-low reset
//   slave_req/gnt   register access handshake; gnt is a copy of req
//   slave_addr/we/be/wdata   register access; only addr[4:2] decoded, be ignored
//   slave_rvalid/rdata/err   registered response, one cycle after gnt
//   master_req/gnt  DMA request handshake
//   master_addr/we/be/wdata  DMA request payload, held while req && !gnt
//   master_rvalid/rdata/err  DMA response
//   irq_o           level interrupt = IE & (DONE | ERROR)
module cipher_dma #(
  parameter int LEN_W = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        slave_req,
  output logic        slave_gnt,
  input  logic [31:0] slave_addr,
  input  logic        slave_we,
  input  logic [3:0]  slave_be,
  input  logic [31:0] slave_wdata,
  output logic        slave_rvalid,
  output logic [31:0] slave_rdata,
  output logic        slave_err,
  output logic        master_req,
  input  logic        master_gnt,
  output logic [31:0] master_addr,
  output logic        master_we,
  output logic [3:0]  master_be,
  output logic [31:0] master_wdata,
  input  logic        master_rvalid,
  input  logic [31:0] master_rdata,
  input  logic        master_err,
  output logic        irq_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_WR_WAIT = 3'd4;

  localparam logic [2:0] R_CTRL   = 3'd0;
  localparam logic [2:0] R_STATUS = 3'd1;
  localparam logic [2:0] R_SRC    = 3'd2;
  localparam logic [2:0] R_DST    = 3'd3;
  localparam logic [2:0] R_LEN    = 3'd4;
  localparam logic [2:0] R_KEY    = 3'd5;
  localparam logic [2:0] R_COUNT  = 3'd6;
  localparam logic [2:0] R_BAD    = 3'd7;

  logic [2:0]       state_q, state_d;
  logic             ie_q, ie_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      key_q, key_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [31:0]      ks_q, ks_d;
  logic [31:0]      buf_q, buf_d;
  logic             rvalid_q, rvalid_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             serr_q, serr_d;

  logic [2:0]       reg_idx;
  logic             reg_wr;
  logic             busy;
  logic             start;
  logic [31:0]      rd_mux;
  logic [31:0]      addr_off;
  logic [31:0]      ks_next;
  logic [LEN_W-1:0] count_inc;
  logic             unused_ok;

  assign unused_ok = ^{slave_be, slave_addr[31:5], slave_addr[1:0]};

  assign reg_idx   = slave_addr[4:2];
  assign reg_wr    = slave_req & slave_we;
  assign busy      = (state_q != S_IDLE);
  assign start     = reg_wr & (reg_idx == R_CTRL) & slave_wdata[0] & ~busy;
  assign addr_off  = 32'(count_q) << 2;
  assign ks_next   = {ks_q[30:0], ks_q[31] ^ ks_q[21] ^ ks_q[1] ^ ks_q[0]};
  assign count_inc = count_q + LEN_W'(1);

  assign slave_gnt    = slave_req;
  assign slave_rvalid = rvalid_q;
  assign slave_rdata  = rdata_q;
  assign slave_err    = serr_q;

  // Master payload is decoded from state, so it stays frozen while waiting for gnt
  // and collapses to zero the instant reset forces the state back to IDLE.
  assign master_req   = (state_q == S_RD_REQ) | (state_q == S_WR_REQ);
  assign master_we    = (state_q == S_WR_REQ);
  assign master_be    = 4'hF;
  assign master_addr  = (state_q == S_RD_REQ) ? src_q + addr_off :
                        (state_q == S_WR_REQ) ? dst_q + addr_off : 32'h0;
  assign master_wdata = (state_q == S_WR_REQ) ? buf_q : 32'h0;

  assign irq_o = ie_q & (done_q | error_q);

  always_comb begin
    rd_mux = 32'h0;
    case (reg_idx)
      R_CTRL:   rd_mux = {30'h0, ie_q, 1'b0};
      R_STATUS: rd_mux = {29'h0, error_q, done_q, busy};
      R_SRC:    rd_mux = src_q;
      R_DST:    rd_mux = dst_q;
      R_LEN:    rd_mux = 32'(len_q);
      R_KEY:    rd_mux = key_q;
      R_COUNT:  rd_mux = 32'(count_q);
      default:  rd_mux = 32'h0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ie_d     = ie_q;
    done_d   = done_q;
    error_d  = error_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    key_d    = key_q;
    count_d  = count_q;
    ks_d     = ks_q;
    buf_d    = buf_q;

    rvalid_d = slave_req;
    serr_d   = slave_req & (reg_idx == R_BAD);
    rdata_d  = (slave_req & ~slave_we) ? rd_mux : 32'h0;

    // Job parameters are frozen while a job runs, so they double as the snapshot.
    if (reg_wr && !busy) begin
      case (reg_idx)
        R_SRC:   src_d = {slave_wdata[31:2], 2'b00};
        R_DST:   dst_d = {slave_wdata[31:2], 2'b00};
        R_LEN:   len_d = slave_wdata[LEN_W-1:0];
        R_KEY:   key_d = slave_wdata;
        default: ;
      endcase
    end

    if (reg_wr && reg_idx == R_CTRL) ie_d = slave_wdata[1];

    if (reg_wr && reg_idx == R_STATUS) begin
      if (slave_wdata[1]) done_d  = 1'b0;
      if (slave_wdata[2]) error_d = 1'b0;
    end

    if (start) begin
      error_d = 1'b0;
      count_d = '0;
      ks_d    = key_q;
      if (len_q == '0) begin
        done_d = 1'b1;
      end else begin
        done_d  = 1'b0;
        state_d = S_RD_REQ;
      end
    end

    // Hardware sets of DONE/ERROR come after the W1C handling so they win.
    case (state_q)
      S_RD_REQ: if (master_gnt) state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (master_rvalid) begin
          if (master_err) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            buf_d   = master_rdata ^ ks_q;
            ks_d    = ks_next;
            state_d = S_WR_REQ;
          end
        end
      end
      S_WR_REQ: if (master_gnt) state_d = S_WR_WAIT;
      S_WR_WAIT: begin
        if (master_rvalid) begin
          if (master_err) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            count_d = count_inc;
            if (count_inc == len_q) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_RD_REQ;
            end
          end
        end
      end
      S_IDLE: ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      ie_q     <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      src_q    <= 32'h0;
      dst_q    <= 32'h0;
      len_q    <= '0;
      key_q    <= 32'h0;
      count_q  <= '0;
      ks_q     <= 32'h0;
      buf_q    <= 32'h0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
      serr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ie_q     <= ie_d;
      done_q   <= done_d;
      error_q  <= error_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      key_q    <= key_d;
      count_q  <= count_d;
      ks_q     <= ks_d;
      buf_q    <= buf_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      serr_q   <= serr_d;
    end
  end

endmodule

// File: tb/tb_cipher_dma.sv
// tb/tb_cipher_dma.sv - self-checking bench for cipher_dma against a queue-based job model
module tb_cipher_dma;

  localparam logic [31:0] A_CTRL   = 32'h00;
  localparam logic [31:0] A_STATUS = 32'h04;
  localparam logic [31:0] A_SRC    = 32'h08;
  localparam logic [31:0] A_DST    = 32'h0C;
  localparam logic [31:0] A_LEN    = 32'h10;
  localparam logic [31:0] A_KEY    = 32'h14;
  localparam logic [31:0] A_COUNT  = 32'h18;
  localparam logic [31:0] A_BAD    = 32'h1C;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        slave_req = 1'b0;
  logic        slave_gnt;
  logic [31:0] slave_addr = 32'h0;
  logic        slave_we = 1'b0;
  logic [3:0]  slave_be = 4'hF;
  logic [31:0] slave_wdata = 32'h0;
  logic        slave_rvalid;
  logic [31:0] slave_rdata;
  logic        slave_err;
  logic        master_req;
  logic        master_gnt = 1'b0;
  logic [31:0] master_addr;
  logic        master_we;
  logic [3:0]  master_be;
  logic [31:0] master_wdata;
  logic        master_rvalid = 1'b0;
  logic [31:0] master_rdata = 32'h0;
  logic        master_err = 1'b0;
  logic        irq_o;

  always #5 clk_i = ~clk_i;

  cipher_dma dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .slave_req(slave_req), .slave_gnt(slave_gnt), .slave_addr(slave_addr),
    .slave_we(slave_we), .slave_be(slave_be), .slave_wdata(slave_wdata),
    .slave_rvalid(slave_rvalid), .slave_rdata(slave_rdata), .slave_err(slave_err),
    .master_req(master_req), .master_gnt(master_gnt), .master_addr(master_addr),
    .master_we(master_we), .master_be(master_be), .master_wdata(master_wdata),
    .master_rvalid(master_rvalid), .master_rdata(master_rdata), .master_err(master_err),
    .irq_o(irq_o)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        cur;
  logic [31:0] mem [logic [31:0]];
  int          n_checks = 0;
  int          n_fail = 0;
  int          bp = 0;
  int          err_read = 0;
  int          rd_cnt = 0;
  int          cyc = 0;
  int          exp_count = 0;
  logic [31:0] exp_status = 32'h0;
  bit          saw_req = 0;
  bit          hold_valid = 0;
  logic [31:0] hold_addr, hold_wdata;
  logic        hold_we;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  function automatic logic [31:0] lfsr(input logic [31:0] k);
    return {k[30:0], k[31] ^ k[21] ^ k[1] ^ k[0]};
  endfunction

  task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er);
    @(posedge clk_i); #1;
    slave_req = 1'b1; slave_we = we; slave_addr = addr; slave_wdata = wd;
    @(posedge clk_i); #1;
    slave_req = 1'b0; slave_we = 1'b0;
    check("slave_rvalid", 32'(slave_rvalid), 32'h1);
    rd = slave_rdata;
    er = slave_err;
  endtask

  // Memory: grant after 0..5 cycles and respond 1..4 cycles later under
  // backpressure, otherwise grant immediately and respond next cycle.
  initial begin : responder
    bit          pend;
    int          rcnt;
    int          gwait;
    logic [31:0] rdat;
    logic        rerr;
    pend = 0; rcnt = 0; gwait = -1; rdat = 0; rerr = 0;
    forever begin
      @(posedge clk_i); #1;
      master_gnt = 1'b0; master_rvalid = 1'b0; master_err = 1'b0; master_rdata = 32'h0;
      if (pend) begin
        if (rcnt <= 1) begin
          master_rvalid = 1'b1; master_rdata = rdat; master_err = rerr; pend = 0;
        end else begin
          rcnt--;
        end
      end else if (master_req) begin
        if (gwait < 0) gwait = (bp != 0) ? int'($urandom_range(0, 5)) : 0;
        if (gwait == 0) begin
          master_gnt = 1'b1; gwait = -1; pend = 1;
          rcnt = (bp != 0) ? int'($urandom_range(1, 4)) : 1;
          rerr = 1'b0; rdat = 32'h0;
          if (master_we) begin
            mem[master_addr] = master_wdata;
          end else begin
            rd_cnt++;
            rdat = rd_mem(master_addr);
            rerr = (rd_cnt == err_read);
          end
        end else begin
          gwait--;
        end
      end
    end
  end

  // Every accepted master request must be the next one the job model predicts,
  // and a stalled request must not change until it is granted.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      hold_valid = 0;
    end else begin
      if (master_req) saw_req = 1;
      if (hold_valid && master_req) begin
        check("hold_addr", master_addr, hold_addr);
        check("hold_we", 32'(master_we), 32'(hold_we));
        check("hold_wdata", master_wdata, hold_wdata);
      end
      if (master_req && master_gnt) begin
        check("txn_expected", 32'(exp_q.size() != 0), 32'h1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          check("txn_we", 32'(master_we), 32'(cur.we));
          check("txn_addr", master_addr, cur.addr);
          if (cur.we) check("txn_wdata", master_wdata, cur.data);
          check("txn_be", 32'(master_be), 32'hF);
        end
      end
      hold_valid = master_req && !master_gnt;
      hold_addr  = master_addr;
      hold_we    = master_we;
      hold_wdata = master_wdata;
    end
  end

  // Model of a job: the transfer list and the final STATUS/COUNT are derived
  // from memory contents and the keystream rule before START is issued.
  task automatic start_job(input logic [31:0] src, input logic [31:0] dst, input int len,
                           input logic [31:0] key, input int bp_i, input int err_i);
    logic [31:0] ks, rd;
    logic        er;
    txn_t        t;
    bp = bp_i; err_read = err_i; rd_cnt = 0;
    exp_q.delete();
    bus(1'b1, A_SRC, src, rd, er);
    bus(1'b1, A_DST, dst, rd, er);
    bus(1'b1, A_LEN, 32'(len), rd, er);
    bus(1'b1, A_KEY, key, rd, er);
    ks = key;
    exp_count = len;
    exp_status = 32'h2;
    for (int i = 0; i < len; i++) begin
      t.we = 1'b0; t.addr = src + 32'(4 * i); t.data = 32'h0;
      exp_q.push_back(t);
      if (err_i == i + 1) begin
        exp_count = i;
        exp_status = 32'h4;
        break;
      end
      t.we = 1'b1; t.addr = dst + 32'(4 * i); t.data = rd_mem(src + 32'(4 * i)) ^ ks;
      exp_q.push_back(t);
      ks = lfsr(ks);
    end
    bus(1'b1, A_CTRL, 32'h3, rd, er);
    cyc = 1;
  endtask

  task automatic finish_job(input logic [31:0] len_prog, input bit poke);
    logic [31:0] rd;
    logic        er;
    if (poke) begin
      bus(1'b1, A_LEN, 32'h99, rd, er);
      bus(1'b0, A_STATUS, 32'h0, rd, er);
      check("busy_during_job", rd & 32'h1, 32'h1);
      cyc += 4;
    end
    while (!irq_o && cyc < 3000) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    check("job_irq", 32'(irq_o), 32'h1);
    bus(1'b0, A_STATUS, 32'h0, rd, er);
    check("job_status", rd & 32'h7, exp_status);
    bus(1'b0, A_COUNT, 32'h0, rd, er);
    check("job_count", rd, 32'(exp_count));
    if (poke) begin
      bus(1'b0, A_LEN, 32'h0, rd, er);
      check("len_frozen_busy", rd, len_prog);
    end
    repeat (8) @(posedge clk_i);
    #1;
    check("job_txns_left", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] rd, key, key2;
    logic        er;
    logic [31:0] orig [8];
    int          k;

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_master_req", 32'(master_req), 32'h0);
    check("rst_master_addr", master_addr, 32'h0);
    check("rst_master_be", 32'(master_be), 32'hF);
    check("rst_irq", 32'(irq_o), 32'h0);
    check("rst_slave_rvalid", 32'(slave_rvalid), 32'h0);
    rst_ni = 1'b1;
    bus(1'b0, A_STATUS, 32'h0, rd, er);
    check("rst_status", rd, 32'h0);
    bus(1'b0, A_KEY, 32'h0, rd, er);
    check("rst_key", rd, 32'h0);
    check("model_lfsr", lfsr(32'hA5A5A5A5), 32'h4B4B4B4B);

    // Single word, zero-wait memory: result and completion latency.
    mem[32'h1000] = 32'h12345678;
    start_job(32'h1000, 32'h2000, 1, 32'hA5A5A5A5, 0, 0);
    finish_job(32'h1, 1'b0);
    check("t1_result", rd_mem(32'h2000), 32'hB791F3DD);
    check("t1_cycles_to_done", 32'(cyc), 32'h5);

    // Round trip with random data, then the same job under backpressure.
    key = $urandom;
    for (int i = 0; i < 8; i++) begin
      orig[i] = $urandom;
      mem[32'h3000 + 32'(4 * i)] = orig[i];
    end
    start_job(32'h3000, 32'h4000, 8, key, 0, 0);
    finish_job(32'h8, 1'b0);
    start_job(32'h4000, 32'h3000, 8, key, 0, 0);
    finish_job(32'h8, 1'b0);
    for (int i = 0; i < 8; i++)
      check("roundtrip_restore", rd_mem(32'h3000 + 32'(4 * i)), orig[i]);
    start_job(32'h3000, 32'h5000, 8, key, 1, 0);
    finish_job(32'h8, 1'b0);
    for (int i = 0; i < 8; i++)
      check("backpressure_same", rd_mem(32'h5000 + 32'(4 * i)), rd_mem(32'h4000 + 32'(4 * i)));

    // Error on the 3rd read of a LEN=5 job.
    for (int i = 0; i < 5; i++) mem[32'h6000 + 32'(4 * i)] = $urandom;
    mem[32'h7008] = 32'hDEADBEEF;
    start_job(32'h6000, 32'h7000, 5, $urandom, 0, 3);
    finish_job(32'h5, 1'b0);
    check("err_no_3rd_write", rd_mem(32'h7008), 32'hDEADBEEF);
    bus(1'b1, A_STATUS, 32'h4, rd, er);
    check("err_w1c_irq", 32'(irq_o), 32'h0);
    bus(1'b0, A_STATUS, 32'h0, rd, er);
    check("err_w1c_status", rd, 32'h0);

    // LEN=0 completes without touching the master port.
    saw_req = 0;
    bus(1'b1, A_LEN, 32'h0, rd, er);
    bus(1'b1, A_CTRL, 32'h3, rd, er);
    bus(1'b0, A_STATUS, 32'h0, rd, er);
    check("len0_status", rd, 32'h2);
    check("len0_irq", 32'(irq_o), 32'h1);
    repeat (5) @(posedge clk_i);
    #1;
    check("len0_no_req", 32'(saw_req), 32'h0);

    // LEN write while busy is dropped.
    for (int i = 0; i < 4; i++) mem[32'hC000 + 32'(4 * i)] = $urandom;
    start_job(32'hC000, 32'hD000, 4, $urandom, 0, 0);
    finish_job(32'h4, 1'b1);

    // Unmapped offset.
    bus(1'b0, A_BAD, 32'h0, rd, er);
    check("bad_rd_err", 32'(er), 32'h1);
    check("bad_rd_data", rd, 32'h0);
    bus(1'b1, A_BAD, 32'hFFFFFFFF, rd, er);
    check("bad_wr_err", 32'(er), 32'h1);

    // W1C of DONE landing on the same edge that sets DONE.
    mem[32'hA000] = $urandom;
    start_job(32'hA000, 32'hB000, 1, $urandom, 0, 0);
    repeat (2) @(posedge clk_i);
    bus(1'b1, A_STATUS, 32'h2, rd, er);
    bus(1'b0, A_STATUS, 32'h0, rd, er);
    check("w1c_race_done", rd, 32'h2);
    bus(1'b1, A_STATUS, 32'h2, rd, er);
    bus(1'b0, A_STATUS, 32'h0, rd, er);
    check("w1c_clear_done", rd, 32'h0);

    // Asynchronous reset while in WR_WAIT, then a clean job.
    for (int i = 0; i < 4; i++) mem[32'h8000 + 32'(4 * i)] = $urandom;
    start_job(32'h8000, 32'h9000, 4, $urandom, 1, 0);
    k = 0;
    do begin
      @(negedge clk_i);
      k++;
    end while (!(master_req && master_gnt && master_we) && k < 400);
    check("reach_wr_wait", 32'(k < 400), 32'h1);
    @(posedge clk_i); #2;
    rst_ni = 1'b0;
    #1;
    check("arst_master_req", 32'(master_req), 32'h0);
    check("arst_master_we", 32'(master_we), 32'h0);
    check("arst_master_addr", master_addr, 32'h0);
    check("arst_master_wdata", master_wdata, 32'h0);
    check("arst_irq", 32'(irq_o), 32'h0);
    check("arst_slave_rvalid", 32'(slave_rvalid), 32'h0);
    exp_q.delete();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    bus(1'b0, A_COUNT, 32'h0, rd, er);
    check("arst_count", rd, 32'h0);
    bus(1'b0, A_STATUS, 32'h0, rd, er);
    check("arst_status", rd, 32'h0);
    key2 = $urandom;
    start_job(32'h8000, 32'h9000, 4, key2, 0, 0);
    finish_job(32'h4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
